// File: rtl/nibble_link_pkg.sv
// Shared constants and types for the nibble-load link (initiator and peer).
// Control codes, acknowledge patterns and the initiator state enum live here.
package nibble_link_pkg;

  localparam logic [1:0] CTL_LOW_NIBBLE  = 2'b00;
  localparam logic [1:0] CTL_HIGH_NIBBLE = 2'b01;
  localparam logic [1:0] CTL_IDLE        = 2'b10;

  localparam logic [7:0] ACK_LO_PATTERN = 8'h0F;
  localparam logic [7:0] ACK_HI_PATTERN = 8'hF0;

  // Wait counter width; covers the largest legal timeout of 255 cycles.
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SEND_LO = 2'b01,
    SEND_HI = 2'b10
  } state_t;

  function automatic logic [1:0] ctl_for_state(input state_t s);
    case (s)
      SEND_LO: return CTL_LOW_NIBBLE;
      SEND_HI: return CTL_HIGH_NIBBLE;
      default: return CTL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/nibble_link_timer.sv
// Per-nibble wait counter: clear has priority over enable, terminal flag
// rises when the count reaches TIMEOUT_CYCLES-1.
module nibble_link_timer
  import nibble_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_terminal
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_terminal = (r_count == LIMIT);

endmodule

// File: rtl/nibble_link_tx.sv
// Nibble-load link initiator: sends each byte as low then high nibble and
// waits for the matching ack pattern, aborting on a per-nibble timeout.
module nibble_link_tx
  import nibble_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter logic [7:0]  ACK_LO         = ACK_LO_PATTERN,
  parameter logic [7:0]  ACK_HI         = ACK_HI_PATTERN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [1:0] link_ctl,
  output logic [3:0] link_data,
  input  logic [7:0] link_ack,
  output logic       tx_done,
  output logic       tx_timeout,
  output logic       err_sticky,
  input  logic       err_clear,
  output logic [7:0] byte_count,
  output state_t     dbg_state
);

  // Handshake: a byte is taken on any edge where tx_valid && tx_ready.
  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_byte;
  logic       r_tx_ready;
  logic [1:0] r_link_ctl;
  logic [3:0] r_link_data;
  logic       r_done;
  logic       r_timeout;
  logic       r_err;
  logic [7:0] r_byte_count;

  logic w_accept;
  logic w_terminal;
  logic w_timer_clr;
  logic w_timer_en;
  logic w_done;
  logic w_timeout;

  assign w_accept = tx_valid && r_tx_ready;

  nibble_link_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_timer_clr),
    .i_en       (w_timer_en),
    .o_terminal (w_terminal)
  );

  // A correct ack wins over the terminal count on the same edge.
  always_comb begin
    w_next_state = r_state;
    w_timer_clr  = 1'b0;
    w_timer_en   = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SEND_LO;
          w_timer_clr  = 1'b1;
        end
      end
      SEND_LO: begin
        if (link_ack == ACK_LO) begin
          w_next_state = SEND_HI;
          w_timer_clr  = 1'b1;
        end else if (w_terminal) begin
          w_next_state = IDLE;
          w_timer_clr  = 1'b1;
          w_timeout    = 1'b1;
        end else begin
          w_timer_en = 1'b1;
        end
      end
      SEND_HI: begin
        if (link_ack == ACK_HI) begin
          w_next_state = IDLE;
          w_timer_clr  = 1'b1;
          w_done       = 1'b1;
        end else if (w_terminal) begin
          w_next_state = IDLE;
          w_timer_clr  = 1'b1;
          w_timeout    = 1'b1;
        end else begin
          w_timer_en = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_byte       <= '0;
      r_tx_ready   <= 1'b1;
      r_link_ctl   <= CTL_IDLE;
      r_link_data  <= '0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_err        <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_state    <= w_next_state;
      r_tx_ready <= (w_next_state == IDLE);
      r_link_ctl <= ctl_for_state(w_next_state);
      r_done     <= w_done;
      r_timeout  <= w_timeout;
      if (w_accept) r_byte <= tx_data;
      // On the accept edge r_byte is not yet loaded, so take the nibble from tx_data.
      case (w_next_state)
        SEND_LO: r_link_data <= w_accept ? tx_data[3:0] : r_byte[3:0];
        SEND_HI: r_link_data <= r_byte[7:4];
        default: r_link_data <= '0;
      endcase
      if (w_timeout)      r_err <= 1'b1;
      else if (err_clear) r_err <= 1'b0;
      if (w_done) r_byte_count <= r_byte_count + 1'b1;
    end
  end

  assign tx_ready   = r_tx_ready;
  assign link_ctl   = r_link_ctl;
  assign link_data  = r_link_data;
  assign tx_done    = r_done;
  assign tx_timeout = r_timeout;
  assign err_sticky = r_err;
  assign byte_count = r_byte_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_nibble_link_tx.sv
// Bench for nibble_link_tx: a delay-programmable peer, a timing-level
// reference model feeding expected queues, and a negedge monitor.
module tb_nibble_link_tx;
  import nibble_link_pkg::*;

  localparam int T     = 8;
  localparam int NEVER = 1000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [1:0] link_ctl;
  logic [3:0] link_data;
  logic [7:0] link_ack = 8'h00;
  logic       tx_done;
  logic       tx_timeout;
  logic       err_sticky;
  logic       err_clear = 1'b0;
  logic [7:0] byte_count;
  state_t     dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_link_tx #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .link_ctl   (link_ctl),
    .link_data  (link_data),
    .link_ack   (link_ack),
    .tx_done    (tx_done),
    .tx_timeout (tx_timeout),
    .err_sticky (err_sticky),
    .err_clear  (err_clear),
    .byte_count (byte_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- peer model ----------------
  // Registers the ack one cycle after seeing ctl; answers a phase only once
  // that ctl has been seen for more than peer_dlo / peer_dhi cycles.
  int         peer_dlo = 0;
  int         peer_dhi = 0;
  int         peer_wrong = 0;
  logic [1:0] peer_prev = 2'b10;
  int         peer_age = 0;

  function automatic logic [7:0] wrong_val(input bit hi_phase);
    case (peer_wrong)
      1:       return 8'hFF;
      2:       return hi_phase ? 8'h0F : 8'hF0;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    int age;
    age = (link_ctl != peer_prev) ? 0 : peer_age + 1;
    peer_age  <= age;
    peer_prev <= link_ctl;
    case (link_ctl)
      2'b00:   link_ack <= (age >= peer_dlo) ? 8'h0F : wrong_val(1'b0);
      2'b01:   link_ack <= (age >= peer_dhi) ? 8'hF0 : wrong_val(1'b1);
      default: link_ack <= 8'h00;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [40:0] exp_evt_q[$];  // {is_done, byte_count, edge}
  logic [5:0]  exp_nib_q[$];  // {ctl, nibble}
  logic [7:0]  model_count = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Outcome of one byte from the peer's answer delays: a phase answered with
  // delay d succeeds d+2 edges after entry if that is within T edges.
  task automatic model_expect(input logic [7:0] d, input int dlo, input int dhi,
                              input int acc, input bit track);
    int hs;
    exp_nib_q.push_back({2'b00, d[3:0]});
    if (dlo + 2 <= T) begin
      hs = acc + dlo + 2;
      exp_nib_q.push_back({2'b01, d[7:4]});
      if (track) begin
        if (dhi + 2 <= T) begin
          model_count = model_count + 8'd1;
          exp_evt_q.push_back({1'b1, model_count, 32'(hs + dhi + 2)});
        end else begin
          exp_evt_q.push_back({1'b0, model_count, 32'(hs + T)});
        end
      end
    end else if (track) begin
      exp_evt_q.push_back({1'b0, model_count, 32'(acc + T)});
    end
  endtask

  // ---------------- monitor ----------------
  logic [1:0] mon_prev_ctl = 2'b10;

  always @(negedge clk) begin
    logic [40:0] e;
    logic [5:0]  n;
    if (tx_done || tx_timeout) begin
      if (exp_evt_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: done=%0b timeout=%0b at edge %0d, expected none",
                 tx_done, tx_timeout, cyc);
      end else begin
        e = exp_evt_q.pop_front();
        check("evt_kind", 32'({tx_done, tx_timeout}), e[40] ? 32'd2 : 32'd1);
        check("evt_edge", 32'(cyc), e[31:0]);
        check("evt_byte_count", 32'(byte_count), 32'(e[39:32]));
        if (!e[40]) check("evt_err_sticky", 32'(err_sticky), 32'd1);
      end
    end
    if (link_ctl != mon_prev_ctl) begin
      if (link_ctl == 2'b10) begin
        check("idle_link_data", 32'(link_data), 32'd0);
      end else if (exp_nib_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_nibble: ctl=%0b data=%0h, expected none", link_ctl, link_data);
      end else begin
        n = exp_nib_q.pop_front();
        check("nibble_ctl_data", 32'({link_ctl, link_data}), 32'(n));
      end
    end
    mon_prev_ctl <= link_ctl;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send_byte(input logic [7:0] d, input int dlo, input int dhi,
                           input int wrong, input bit track, output int acc);
    int waited;
    waited     = 0;
    peer_dlo   = dlo;
    peer_dhi   = dhi;
    peer_wrong = wrong;
    tx_data    = d;
    tx_valid   = 1'b1;
    while (!tx_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_wait: tx_ready=%0b after %0d cycles, expected 1", tx_ready, waited);
      tx_valid = 1'b0;
      acc = cyc;
    end else begin
      acc = cyc + 1;
      model_expect(d, dlo, dhi, acc, track);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tx_valid = 1'b0;
    @(negedge clk);
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_wait: tx_ready=%0b after %0d cycles, expected 1", tx_ready, n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int acc_prev;
    int dlo;
    int dhi;

    repeat (3) @(negedge clk);
    check("rst_link_ctl", 32'(link_ctl), 32'd2);
    check("rst_link_data", 32'(link_data), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_tx_timeout", 32'(tx_timeout), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Single byte, immediate peer.
    send_byte(8'hA5, 0, 0, 0, 1'b1, acc);
    wait_idle();
    check("single_byte_count", 32'(byte_count), 32'd1);

    // Reset while in SEND_HI aborts silently.
    send_byte(8'h3C, 0, NEVER, 0, 1'b0, acc);
    tx_valid = 1'b0;
    while (cyc < acc + 3) @(negedge clk);
    check("pre_reset_ctl", 32'(link_ctl), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_count = 8'h00;
    check("mid_reset_ctl", 32'(link_ctl), 32'd2);
    check("mid_reset_ready", 32'(tx_ready), 32'd1);
    check("mid_reset_done", 32'(tx_done), 32'd0);
    check("mid_reset_timeout", 32'(tx_timeout), 32'd0);
    check("mid_reset_count", 32'(byte_count), 32'd0);
    repeat (T + 4) @(negedge clk);

    // Back-to-back with tx_valid held.
    send_byte(8'h12, 0, 0, 0, 1'b1, acc);
    acc_prev = acc;
    send_byte(8'h34, 0, 0, 0, 1'b1, acc);
    check("b2b_spacing_1", 32'(acc - acc_prev), 32'd5);
    acc_prev = acc;
    send_byte(8'hFF, 0, 0, 0, 1'b1, acc);
    check("b2b_spacing_2", 32'(acc - acc_prev), 32'd5);
    wait_idle();
    check("b2b_byte_count", 32'(byte_count), 32'd3);

    // Peer never acks (stuck 0xFF).
    send_byte(8'h5A, NEVER, NEVER, 1, 1'b1, acc);
    wait_idle();
    check("never_err_sticky", 32'(err_sticky), 32'd1);
    check("never_byte_count", 32'(byte_count), 32'd3);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("clear_err_sticky", 32'(err_sticky), 32'd0);

    // Low ack only; err_clear coincides with the SEND_HI timeout.
    send_byte(8'hC3, 0, NEVER, 2, 1'b1, acc);
    tx_valid = 1'b0;
    while (cyc < acc + 1 + T) @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    check("clr_vs_timeout_pulse", 32'(tx_timeout), 32'd1);
    check("clr_vs_timeout_sticky", 32'(err_sticky), 32'd1);
    @(negedge clk);
    err_clear = 1'b0;
    check("clr_alone_sticky", 32'(err_sticky), 32'd0);
    wait_idle();

    // Ack lands on the terminal count in both phases.
    send_byte(8'h69, T - 2, T - 2, 0, 1'b1, acc);
    wait_idle();
    check("limit_ack_no_err", 32'(err_sticky), 32'd0);
    // One cycle later is a timeout.
    send_byte(8'h96, T - 1, 0, 2, 1'b1, acc);
    wait_idle();
    check("late_ack_err", 32'(err_sticky), 32'd1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;

    // Random bytes, delays and wrong-ack styles.
    for (int i = 0; i < 40; i++) begin
      dlo = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, T));
      dhi = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, T));
      send_byte(8'($urandom_range(0, 255)), dlo, dhi, int'($urandom_range(0, 2)), 1'b1, acc);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Fill up to 255 delivered bytes, then wrap.
    while (model_count != 8'hFF) begin
      send_byte(8'($urandom_range(0, 255)), 0, 0, 0, 1'b1, acc);
    end
    wait_idle();
    check("count_255", 32'(byte_count), 32'd255);
    send_byte(8'h81, 0, 0, 0, 1'b1, acc);
    wait_idle();
    check("count_wrap", 32'(byte_count), 32'd0);

    repeat (T + 4) @(negedge clk);
    check("evt_queue_empty", 32'(exp_evt_q.size()), 32'd0);
    check("nib_queue_empty", 32'(exp_nib_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
